// File: rtl/i2c_cmd_sched_if.sv
// Bundles the command push port, the read-data port and the i2c_master handshake.
// slave: the scheduler's view; master: the core / bus-model view.
interface i2c_cmd_sched_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [6:0] cmd_addr;
   logic       cmd_rw;
   logic [7:0] cmd_data;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic       rd_pop;
   logic [6:0] i2c_addr;
   logic [7:0] i2c_data;
   logic       i2c_rw;
   logic       i2c_en;
   logic       i2c_ready;
   logic [7:0] i2c_read_data;
   logic       busy;
   logic       err_timeout;
   logic       err_clear;

   modport slave (
      input  cmd_valid, cmd_addr, cmd_rw, cmd_data, rd_pop,
             i2c_ready, i2c_read_data, err_clear,
      output cmd_ready, rd_valid, rd_data, i2c_addr, i2c_data, i2c_rw,
             i2c_en, busy, err_timeout
   );

   modport master (
      output cmd_valid, cmd_addr, cmd_rw, cmd_data, rd_pop,
             i2c_ready, i2c_read_data, err_clear,
      input  cmd_ready, rd_valid, rd_data, i2c_addr, i2c_data, i2c_rw,
             i2c_en, busy, err_timeout
   );
endinterface

// File: rtl/i2c_cmd_sched.sv
// Queues I2C commands, issues them one at a time to i2c_master and buffers read bytes
// in a show-ahead FIFO. Define I2C_SCHED_TIMEOUT_EN to enable the wait-state abort.
module i2c_cmd_sched #(
   parameter int DEPTH          = 4,
   parameter int RD_DEPTH       = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input logic            clk,
   input logic            reset,
   i2c_cmd_sched_if.slave bus
);
   localparam int AW  = $clog2(DEPTH);
   localparam int RAW = $clog2(RD_DEPTH);
   localparam logic [AW:0]  CMD_FULL = (AW + 1)'(DEPTH);
   localparam logic [RAW:0] RD_FULL  = (RAW + 1)'(RD_DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;
   typedef struct packed {
      logic [6:0] addr;
      logic       rw;
      logic [7:0] data;
   } cmd_t;

   state_t         state_q, state_d;
   cmd_t           lat_q, lat_d;
   cmd_t           cmd_mem [DEPTH];
   logic [AW-1:0]  cmd_wptr_q, cmd_wptr_d, cmd_rptr_q, cmd_rptr_d;
   logic [AW:0]    cmd_cnt_q, cmd_cnt_d;
   logic [7:0]     rd_mem [RD_DEPTH];
   logic [RAW-1:0] rd_wptr_q, rd_wptr_d, rd_rptr_q, rd_rptr_d;
   logic [RAW:0]   rd_cnt_q, rd_cnt_d;

   logic cmd_ready, cmd_push, cmd_pop, cmd_empty;
   logic rd_valid, rd_full, rd_push, rd_pop;
   logic tmo_abort;
   cmd_t cmd_head, cmd_in;

   assign cmd_ready = (cmd_cnt_q != CMD_FULL);
   assign cmd_empty = (cmd_cnt_q == '0);
   assign cmd_push  = bus.cmd_valid && cmd_ready;
   assign cmd_in    = '{addr: bus.cmd_addr, rw: bus.cmd_rw, data: bus.cmd_data};
   assign cmd_head  = cmd_mem[cmd_rptr_q];
   assign rd_valid  = (rd_cnt_q != '0);
   assign rd_full   = (rd_cnt_q == RD_FULL);
   assign rd_pop    = bus.rd_pop && rd_valid;

   // Storage arrays carry no reset; pointers and counts define what is valid.
   always_ff @(posedge clk) begin
      if (cmd_push) cmd_mem[cmd_wptr_q] <= cmd_in;
   end

   always_ff @(posedge clk) begin
      if (rd_push) rd_mem[rd_wptr_q] <= bus.i2c_read_data;
   end

   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      cmd_pop = 1'b0;
      rd_push = 1'b0;
      case (state_q)
         IDLE: begin
            // A read is held back until the read FIFO has room for its byte.
            if (!cmd_empty && bus.i2c_ready && (!cmd_head.rw || !rd_full)) begin
               state_d = ISSUE;
               lat_d   = cmd_head;
            end
         end
         ISSUE: begin
            cmd_pop = 1'b1;
            state_d = WAIT_START;
         end
         WAIT_START: begin
            if (!bus.i2c_ready) state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (bus.i2c_ready) begin
               rd_push = lat_q.rw;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (tmo_abort) state_d = IDLE;
   end

   always_comb begin
      cmd_wptr_d = cmd_wptr_q;
      cmd_rptr_d = cmd_rptr_q;
      cmd_cnt_d  = cmd_cnt_q;
      rd_wptr_d  = rd_wptr_q;
      rd_rptr_d  = rd_rptr_q;
      rd_cnt_d   = rd_cnt_q;
      if (cmd_push) cmd_wptr_d = cmd_wptr_q + 1'b1;
      if (cmd_pop)  cmd_rptr_d = cmd_rptr_q + 1'b1;
      if (cmd_push && !cmd_pop)      cmd_cnt_d = cmd_cnt_q + 1'b1;
      else if (cmd_pop && !cmd_push) cmd_cnt_d = cmd_cnt_q - 1'b1;
      if (rd_push) rd_wptr_d = rd_wptr_q + 1'b1;
      if (rd_pop)  rd_rptr_d = rd_rptr_q + 1'b1;
      if (rd_push && !rd_pop)      rd_cnt_d = rd_cnt_q + 1'b1;
      else if (rd_pop && !rd_push) rd_cnt_d = rd_cnt_q - 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         lat_q      <= '0;
         cmd_wptr_q <= '0;
         cmd_rptr_q <= '0;
         cmd_cnt_q  <= '0;
         rd_wptr_q  <= '0;
         rd_rptr_q  <= '0;
         rd_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         lat_q      <= lat_d;
         cmd_wptr_q <= cmd_wptr_d;
         cmd_rptr_q <= cmd_rptr_d;
         cmd_cnt_q  <= cmd_cnt_d;
         rd_wptr_q  <= rd_wptr_d;
         rd_rptr_q  <= rd_rptr_d;
         rd_cnt_q   <= rd_cnt_d;
      end
   end

`ifdef I2C_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          err_q, err_d;

   // A completion seen in the final wait cycle takes priority over the abort.
   assign tmo_abort = (state_q == WAIT_START || (state_q == WAIT_DONE && !bus.i2c_ready))
                      && (tmo_cnt_q == TMO_LAST);

   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      err_d     = err_q;
      if (state_q == ISSUE)
         tmo_cnt_d = '0;
      else if (state_q == WAIT_START || state_q == WAIT_DONE)
         tmo_cnt_d = tmo_cnt_q + 1'b1;
      if (tmo_abort)          err_d = 1'b1;
      else if (bus.err_clear) err_d = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         err_q     <= err_d;
      end
   end

   assign bus.err_timeout = err_q;
`else
   localparam int unused_tmo_cycles = TIMEOUT_CYCLES;
   logic unused_err_clear;

   assign unused_err_clear = bus.err_clear;
   assign tmo_abort        = 1'b0;
   assign bus.err_timeout  = 1'b0;
`endif

   assign bus.cmd_ready = cmd_ready;
   assign bus.rd_valid  = rd_valid;
   assign bus.rd_data   = rd_valid ? rd_mem[rd_rptr_q] : 8'h00;
   assign bus.i2c_addr  = lat_q.addr;
   assign bus.i2c_data  = lat_q.data;
   assign bus.i2c_rw    = lat_q.rw;
   assign bus.i2c_en    = (state_q == ISSUE);
   assign bus.busy      = (state_q != IDLE) || !cmd_empty;
endmodule

// File: tb/tb_i2c_cmd_sched.sv
// Randomized bench for i2c_cmd_sched: a queue-based reference model plus a behavioural
// i2c_master, stepped once per cycle; outputs are sampled on the falling edge.
module tb_i2c_cmd_sched;
   localparam int DEPTH    = 4;
   localparam int RD_DEPTH = 4;
`ifdef I2C_SCHED_TIMEOUT_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 65535;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   i2c_cmd_sched_if ifc ();

   i2c_cmd_sched #(.DEPTH(DEPTH), .RD_DEPTH(RD_DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   typedef struct {
      logic [6:0] addr;
      logic       rw;
      logic [7:0] data;
   } cmd_t;

   cmd_t       cq[$];
   logic [7:0] rq[$];
   logic [7:0] issued_data[$];
   int n_checks = 0;
   int n_errors = 0;

   bit         push_req, pop_req, clr_req, hold_low, m_stuck, accepted;
   logic [6:0] push_addr;
   bit         push_rw;
   logic [7:0] push_data;
   int         m_pre, m_low, m_rdata;

   int         m_phase, m_cnt, since_en, en_count, gap;
   bit         inflight, cur_rw, prev_en, exp_err;
   logic [6:0] last_addr;
   logic [7:0] last_data;
   logic       last_rw;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      cq.delete();
      rq.delete();
      m_phase = 0; m_cnt = 0; since_en = 0; gap = 100;
      inflight = 0; cur_rw = 0; prev_en = 0; exp_err = 0;
      last_addr = '0; last_data = '0; last_rw = 1'b0;
      push_req = 0; pop_req = 0; clr_req = 0; hold_low = 0; m_stuck = 0;
      ifc.cmd_valid = 1'b0; ifc.cmd_addr = '0; ifc.cmd_rw = 1'b0; ifc.cmd_data = '0;
      ifc.rd_pop = 1'b0; ifc.err_clear = 1'b0;
      ifc.i2c_ready = 1'b1; ifc.i2c_read_data = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      check("rst_cmd_ready", ifc.cmd_ready, 1);
      check("rst_rd_valid", ifc.rd_valid, 0);
      check("rst_rd_data", ifc.rd_data, 0);
      check("rst_i2c_en", ifc.i2c_en, 0);
      check("rst_i2c_addr", ifc.i2c_addr, 0);
      check("rst_i2c_data", ifc.i2c_data, 0);
      check("rst_i2c_rw", ifc.i2c_rw, 0);
      check("rst_busy", ifc.busy, 0);
      check("rst_err", ifc.err_timeout, 0);
      model_clear();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // One clock cycle: check outputs against the model, then drive inputs for the next edge.
   task automatic step();
      bit en_now, ready_now, complete, abort;
      @(negedge clk);
      en_now    = ifc.i2c_en;
      ready_now = (cq.size() < DEPTH);
      complete  = 0;
      abort     = 0;
      check("cmd_ready", ifc.cmd_ready, ready_now);
      check("busy", ifc.busy, inflight || cq.size() != 0);
      check("rd_valid", ifc.rd_valid, rq.size() != 0);
      if (rq.size() != 0) check("rd_data", ifc.rd_data, rq[0]);
      check("err_timeout", ifc.err_timeout, exp_err);
      gap++;
      if (en_now) begin
         check("en_back_to_back", prev_en, 0);
         check("en_spacing", gap >= 3, 1);
         check("en_has_cmd", cq.size() != 0, 1);
         if (cq.size() != 0) begin
            check("i2c_addr", ifc.i2c_addr, cq[0].addr);
            check("i2c_rw", ifc.i2c_rw, cq[0].rw);
            if (!cq[0].rw) begin
               check("i2c_data", ifc.i2c_data, cq[0].data);
               issued_data.push_back(cq[0].data);
            end else begin
               check("rd_room", rq.size() < RD_DEPTH, 1);
            end
            cur_rw = cq[0].rw;
            last_addr = cq[0].addr; last_data = cq[0].data; last_rw = cq[0].rw;
            void'(cq.pop_front());
         end
         gap = 0;
         en_count++;
         inflight = 1; since_en = 0; m_phase = 1;
         m_cnt = (m_pre >= 0) ? m_pre : int'($urandom_range(0, 3));
      end else begin
         check("hold_addr", ifc.i2c_addr, last_addr);
         check("hold_rw", ifc.i2c_rw, last_rw);
         if (!last_rw) check("hold_data", ifc.i2c_data, last_data);
         if (inflight) since_en++;
         case (m_phase)
            1: begin
               if (m_cnt == 0) begin
                  ifc.i2c_ready = 1'b0;
                  m_phase = 2;
                  m_cnt = (m_low >= 0) ? m_low : int'($urandom_range(0, 5));
               end else m_cnt--;
            end
            2: begin
               if (!m_stuck) begin
                  if (m_cnt == 0) begin
                     ifc.i2c_ready = 1'b1;
                     ifc.i2c_read_data = (m_rdata >= 0) ? 8'(m_rdata) : 8'($urandom);
                     complete = 1; inflight = 0; m_phase = 0;
                  end else m_cnt--;
               end
            end
            default: ifc.i2c_ready = !hold_low;
         endcase
`ifdef I2C_SCHED_TIMEOUT_EN
         if (inflight && since_en == TMO) begin
            abort = 1; exp_err = 1; inflight = 0; m_phase = 0;
         end
`endif
      end
      prev_en = en_now;
      ifc.rd_pop = pop_req;
      if (pop_req && rq.size() != 0) void'(rq.pop_front());
      if (complete && cur_rw) rq.push_back(ifc.i2c_read_data);
      ifc.err_clear = clr_req;
`ifdef I2C_SCHED_TIMEOUT_EN
      if (clr_req && !abort) exp_err = 0;
`endif
      ifc.cmd_valid = push_req;
      ifc.cmd_addr = push_addr; ifc.cmd_rw = push_rw; ifc.cmd_data = push_data;
      accepted = push_req && ready_now;
      if (accepted) cq.push_back('{push_addr, push_rw, push_data});
   endtask

   task automatic push_cmd(input logic [6:0] a, input bit rw, input logic [7:0] d);
      push_req = 1; push_addr = a; push_rw = rw; push_data = d;
      for (int n = 0; n < 60; n++) begin
         step();
         if (accepted) break;
      end
      push_req = 0;
      check("push_accept", accepted, 1);
   endtask

   task automatic drain();
      int n = 0;
      push_req = 0; pop_req = 1; hold_low = 0;
      while ((cq.size() != 0 || inflight || rq.size() != 0) && n < 800) begin
         step();
         n++;
      end
      check("drain_done", (cq.size() == 0 && !inflight && rq.size() == 0), 1);
      pop_req = 0;
      step();
      check("idle_busy", ifc.busy, 0);
   endtask

   initial begin
      int base, n;
      m_pre = -1; m_low = -1; m_rdata = -1; en_count = 0;
      model_clear();
      #2;
      do_reset();

      // Issue latency from an idle scheduler.
      step(); step();
      push_cmd(7'h11, 0, 8'h22);
      step();
      check("lat_en_early", ifc.i2c_en, 0);
      step();
      check("lat_en", ifc.i2c_en, 1);
      drain();

      // Single write with a fixed master timing.
      m_pre = 1; m_low = 10; base = en_count;
      push_cmd(7'h50, 0, 8'hA5);
      drain();
      check("wr_single_en", en_count - base, 1);
      m_pre = -1; m_low = -1;

      // Single read returning 0x3C.
      m_rdata = 8'h3C;
      push_cmd(7'h68, 1, 8'h00);
      n = 0;
      while (rq.size() == 0 && n < 100) begin step(); n++; end
      step();
      check("rd_valid_set", ifc.rd_valid, 1);
      check("rd_byte", ifc.rd_data, 8'h3C);
      pop_req = 1; step(); pop_req = 0; step();
      check("rd_valid_clr", ifc.rd_valid, 0);
      m_rdata = -1;

      // Backpressure: master held busy while five writes are offered.
      hold_low = 1; step();
      issued_data.delete(); base = en_count;
      for (int i = 1; i <= 5; i++) begin
         push_req = 1; push_addr = 7'h20; push_rw = 0; push_data = 8'(i);
         step();
         if (i == 5) begin
            check("bp_fifth_refused", accepted, 0);
            check("bp_ready_low", ifc.cmd_ready, 0);
         end
      end
      push_req = 0;
      drain();
      check("bp_en_count", en_count - base, 4);
      check("bp_issued", issued_data.size(), 4);
      for (int i = 0; i < issued_data.size() && i < 4; i++)
         check("bp_order", issued_data[i], i + 1);

      // Read FIFO full: the fifth read stalls until one byte is popped.
      base = en_count;
      for (int i = 0; i < 5; i++) push_cmd(7'(8'h30 + i), 1, 8'h00);
      for (int i = 0; i < 150; i++) step();
      check("rf_en_count", en_count - base, 4);
      check("rf_rd_valid", ifc.rd_valid, 1);
      pop_req = 1; step(); pop_req = 0;
      step();
      check("rf_en_wait", ifc.i2c_en, 0);
      step();
      check("rf_en_after_pop", ifc.i2c_en, 1);
      drain();

`ifdef I2C_SCHED_TIMEOUT_EN
      // Timeout: master never comes back; a queued command follows after the abort.
      base = en_count; m_stuck = 1;
      push_cmd(7'h40, 0, 8'h01);
      hold_low = 1;
      push_cmd(7'h41, 0, 8'h02);
      for (int i = 0; i < 25; i++) step();
      check("tmo_err_set", ifc.err_timeout, 1);
      check("tmo_one_issue", en_count - base, 1);
      m_stuck = 0;
      hold_low = 0;
      n = 0;
      while (en_count - base < 2 && n < 20) begin step(); n++; end
      check("tmo_next_issued", en_count - base, 2);
      drain();
      clr_req = 1; step(); clr_req = 0; step();
      check("tmo_err_clr", ifc.err_timeout, 0);
`endif

      // Randomized traffic: a pop-heavy half, then a fill-heavy half.
      for (int i = 0; i < 1500; i++) begin
         push_req  = ($urandom_range(0, 2) != 0);
         push_addr = 7'($urandom);
         push_rw   = 1'($urandom);
         push_data = 8'($urandom);
         pop_req   = (i < 750) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
         clr_req   = ($urandom_range(0, 15) == 0);
         step();
      end
      clr_req = 0;
      drain();

      // Reset while waiting on the master with two commands still queued.
      m_pre = 0; m_low = 8;
      for (int i = 0; i < 3; i++) push_cmd(7'h55, 0, 8'(8'hC0 + i));
      n = 0;
      while (m_phase != 2 && n < 40) begin step(); n++; end
      step(); step();
      check("rst_queued", cq.size(), 2);
      check("rst_busy_before", ifc.busy, 1);
      do_reset();
      m_pre = -1; m_low = -1;
      base = en_count;
      for (int i = 0; i < 30; i++) step();
      check("rst_no_en", en_count - base, 0);
      push_cmd(7'h12, 0, 8'h34);
      drain();
      check("rst_new_en", en_count - base, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
